// File: rtl/alu_pkg.sv
// Shared types for the multicycle execute unit: opcode encoding, FSM states and
// the helper that routes an opcode to the iterative multiplier.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_ADD  = 4'd2,
        OP_XOR  = 4'd3,
        OP_NOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SUB  = 4'd6,
        OP_SLT  = 4'd7,
        OP_SLTU = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_MULU = 4'd11,
        OP_MUL  = 4'd12
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: works on operand magnitudes, retires MUL_BPC
// multiplier bits per cycle and negates the product on the final step if needed.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            signed_op,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int STEPS = XLEN / MUL_BPC;
    localparam int CW    = $clog2(STEPS + 1);

    logic [XLEN-1:0]         mcand_q, mcand_d;
    logic [XLEN-1:0]         hi_q, hi_d;
    logic [XLEN-1:0]         lo_q, lo_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    neg_q, neg_d;
    logic                    busy_q, busy_d;
    logic                    last;
    logic [XLEN+MUL_BPC-1:0] partial;
    logic [XLEN+MUL_BPC-1:0] sum;
    logic [2*XLEN+MUL_BPC-1:0] shifted;
    logic [2*XLEN-1:0]       prod_step;

    always_comb begin
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        busy_d    = busy_q;
        last      = busy_q && (cnt_q == CW'(1));
        // Low multiplier digit times the multiplicand joins the running high word.
        partial   = {{MUL_BPC{1'b0}}, mcand_q} * {{XLEN{1'b0}}, lo_q[MUL_BPC-1:0]};
        sum       = {{MUL_BPC{1'b0}}, hi_q} + partial;
        shifted   = {sum, lo_q} >> MUL_BPC;
        prod_step = shifted[2*XLEN-1:0];

        if (abort) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start) begin
            mcand_d = (signed_op && a[XLEN-1]) ? -a : a;
            lo_d    = (signed_op && b[XLEN-1]) ? -b : b;
            hi_d    = '0;
            neg_d   = signed_op && (a[XLEN-1] ^ b[XLEN-1]);
            cnt_d   = CW'(STEPS);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            {hi_d, lo_d} = (last && neg_q) ? -prod_step : prod_step;
            cnt_d        = cnt_q - CW'(1);
            if (last) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = last;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked execute unit: single-cycle ops registered at accept, MUL/MULU run
// in alu_mul_iter. valid/ready: a transfer happens on any edge where both are 1.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] result_hi,
    output logic            zero,
    output logic            overflow,
    output logic            illegal,
    output logic [1:0]      dbg_state
);

    localparam int SHW = $clog2(XLEN);

    state_t          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            ovf_q, ovf_d;
    logic            ill_q, ill_d;
    logic            sel_mul_q, sel_mul_d;

    logic            accept, mul_start, mul_busy, mul_done;
    logic [XLEN-1:0] mul_hi, mul_lo;
    logic [XLEN-1:0] alu_res, b_eff, sum;
    logic            alu_ovf, alu_ill;
    logic [SHW-1:0]  shamt;

    always_comb begin
        shamt   = src_b[SHW-1:0];
        b_eff   = (op == OP_SUB) ? ~src_b : src_b;
        sum     = src_a + b_eff + XLEN'(op == OP_SUB);
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_NOR:  alu_res = ~(src_a | src_b);
            OP_ADD, OP_SUB: begin
                alu_res = sum;
                alu_ovf = (src_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != src_a[XLEN-1]);
            end
            OP_SLT:  alu_res = XLEN'($signed(src_a) < $signed(src_b));
            OP_SLTU: alu_res = XLEN'(src_a < src_b);
            OP_SLL:  alu_res = src_a << shamt;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
            OP_MULU, OP_MUL: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        ill_d     = ill_q;
        sel_mul_d = sel_mul_q;
        in_ready  = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
        accept    = in_valid && in_ready;
        mul_start = accept && is_mul(op);

        case (state_q)
            ST_MUL:  if (mul_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: ;
        endcase

        // An accept in DONE overrides the drop to IDLE, giving back-to-back issue.
        if (accept) begin
            if (is_mul(op)) begin
                state_d   = ST_MUL;
                sel_mul_d = 1'b1;
                ovf_d     = 1'b0;
                ill_d     = 1'b0;
            end else begin
                state_d   = ST_DONE;
                sel_mul_d = 1'b0;
                res_d     = alu_res;
                ovf_d     = alu_ovf;
                ill_d     = alu_ill;
            end
        end

        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            ill_q     <= 1'b0;
            sel_mul_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            ill_q     <= ill_d;
            sel_mul_q <= sel_mul_d;
        end
    end

    alu_mul_iter #(
        .XLEN    (XLEN),
        .MUL_BPC (MUL_BPC)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mul_start),
        .abort     (flush),
        .a         (src_a),
        .b         (src_b),
        .signed_op (op == OP_MUL),
        .busy      (mul_busy),
        .done      (mul_done),
        .hi        (mul_hi),
        .lo        (mul_lo)
    );

    assign out_valid = (state_q == ST_DONE);
    assign result    = sel_mul_q ? mul_lo : res_q;
    assign result_hi = sel_mul_q ? mul_hi : '0;
    assign zero      = out_valid && (result == '0);
    assign overflow  = ovf_q;
    assign illegal   = ill_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (XLEN=32, MUL_BPC=1): directed corner
// cases, handshake/flush/reset scenarios, then randomized ops against a reference model.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        in_ready, out_valid, zero, overflow, illegal;
    logic [31:0] result, result_hi;
    logic [1:0]  dbg_state;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic [31:0] obs_res, obs_hi;
    logic        obs_ovf, obs_ill, obs_zero;

    alu_multicycle #(.XLEN(32), .MUL_BPC(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal),
        .dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural definitions.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] prod, output logic ovf, output logic ill);
        longint sa, sb, s, lim;
        int     sh;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        lim  = 64'sd2147483647;
        sh   = int'(b[4:0]);
        prod = 64'd0;
        ovf  = 1'b0;
        ill  = 1'b0;
        case (o)
            4'd0:  prod = {32'd0, a & b};
            4'd1:  prod = {32'd0, a | b};
            4'd2:  begin s = sa + sb; prod = {32'd0, s[31:0]}; ovf = (s > lim) || (s < -lim - 1); end
            4'd3:  prod = {32'd0, a ^ b};
            4'd4:  prod = {32'd0, ~(a | b)};
            4'd5:  prod = {32'd0, a << sh};
            4'd6:  begin s = sa - sb; prod = {32'd0, s[31:0]}; ovf = (s > lim) || (s < -lim - 1); end
            4'd7:  prod = {63'd0, sa < sb};
            4'd8:  prod = {63'd0, {32'd0, a} < {32'd0, b}};
            4'd9:  prod = {32'd0, a >> sh};
            4'd10: prod = {32'd0, (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0)};
            4'd11: prod = {32'd0, a} * {32'd0, b};
            4'd12: begin s = sa * sb; prod = s; end
            default: ill = 1'b1;
        endcase
    endfunction

    // driver: issue one op, wait for its result, hold it for 'stall' cycles, consume it
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int stall, input string tag);
        logic [63:0] p, e;
        logic        ov, il;
        int          lat, exp_lat;
        model(o, a, b, p, ov, il);
        exp_q.push_back(p);
        exp_lat = (o == 4'd11 || o == 4'd12) ? 33 : 1;
        @(negedge clk);
        op = o; src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b0;
        #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (lat == 5) check({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        repeat (stall) @(negedge clk);
        e = exp_q.pop_front();
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_result"}, 64'(result), {32'd0, e[31:0]});
        check({tag, "_hi"}, 64'(result_hi), {32'd0, e[63:32]});
        check({tag, "_zero"}, 64'(zero), 64'(e[31:0] == 32'd0));
        check({tag, "_ovf"}, 64'(overflow), 64'(ov));
        check({tag, "_ill"}, 64'(illegal), 64'(il));
        obs_res = result; obs_hi = result_hi; obs_ovf = overflow; obs_ill = illegal; obs_zero = zero;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_consumed"}, 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    logic [31:0] specials[6];
    int          seen;

    initial begin
        specials[0] = 32'h0000_0000; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'h8000_0000;
        specials[3] = 32'h7FFF_FFFF; specials[4] = 32'h0000_0001; specials[5] = 32'h0000_001F;

        // reset
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_hi", 64'(result_hi), 64'd0);
        check("rst_flags", {61'd0, zero, overflow, illegal}, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // directed corner cases
        run_op(4'd2, 32'h7FFF_FFFF, 32'h1, 0, "add_ovf");
        check("add_ovf_const", {31'd0, obs_ovf, obs_res}, {31'd0, 1'b1, 32'h8000_0000});
        run_op(4'd6, 32'd5, 32'd5, 0, "sub_zero");
        check("sub_zero_const", 64'(obs_zero), 64'd1);
        run_op(4'd7, 32'hFFFF_FFFF, 32'd1, 0, "slt");
        check("slt_const", 64'(obs_res), 64'd1);
        run_op(4'd8, 32'hFFFF_FFFF, 32'd1, 1, "sltu");
        check("sltu_const", 64'(obs_res), 64'd0);
        run_op(4'd13, 32'h1234, 32'h5678, 0, "illegal");
        check("illegal_const", {31'd0, obs_ill, obs_res}, {31'd0, 1'b1, 32'd0});
        run_op(4'd10, 32'h8000_0000, 32'd36, 0, "sra");
        check("sra_const", 64'(obs_res), 64'hF800_0000);
        run_op(4'd9, 32'h8000_0000, 32'd36, 0, "srl");
        check("srl_const", 64'(obs_res), 64'h0800_0000);
        run_op(4'd5, 32'd1, 32'd31, 0, "sll");
        check("sll_const", 64'(obs_res), 64'h8000_0000);
        run_op(4'd12, 32'hFFFF_FFFD, 32'd7, 0, "mul");
        check("mul_const", {obs_hi, obs_res}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, "mulu");
        check("mulu_const", {obs_hi, obs_res}, 64'hFFFF_FFFE_0000_0001);

        // back-pressure for 5 cycles, then back-to-back accept on release
        @(negedge clk);
        op = 4'd2; src_a = 32'd10; src_b = 32'd20; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_result", 64'(result), 64'd30);
            check("bp_hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1; in_valid = 1'b1; op = 4'd6; src_a = 32'd100; src_b = 32'd1;
        #1 check("b2b_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b_result", 64'(result), 64'd99);
        @(negedge clk);
        check("b2b_drain", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // flush at MUL cycle 10, with an offer that must be ignored
        @(negedge clk);
        op = 4'd12; src_a = 32'd3; src_b = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 4'd2; src_a = 32'd1; src_b = 32'd1;
        #1 check("flush_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_state", 64'(dbg_state), 64'(ST_IDLE));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        // async reset mid-MUL
        @(negedge clk);
        op = 4'd12; src_a = 32'hFFFF_FFFD; src_b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_result", {result_hi, result}, 64'd0);
        check("arst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd12, 32'hFFFF_FFFD, 32'd7, 0, "mul_after_rst");

        // randomized ops
        for (int n = 0; n < 150; n++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            run_op(4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 2), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
